// File: rtl/regfile_timer_pkg.sv
// Shared definitions for the register-file driven interval timer / PWM unit:
// FSM state encoding, control-word bit indices and status-word bit positions.
// Also consumed by the software header generator, so keep values stable.
package regfile_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // control word bit indices
    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_CLR     = 2;
    localparam int CTRL_ACK     = 3;
    localparam int CTRL_IRQ_EN  = 4;

    // status word bit positions
    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_STATE_MSB = 1;
    localparam int STAT_IRQ_PEND  = 2;
    localparam int STAT_OVERRUN   = 3;

endpackage

// File: rtl/regfile_timer_edge.sv
// Purpose: 1-bit rising-edge detector on a register-level command bit.
// Latency: pulse is registered, one cycle after the first clock that samples d high.
// Backpressure: none; single-cycle pulse, history reset to 0 so a bit held high through reset fires once.
// Ports: axi_aclk, axi_aresetn (async active-low), d (level in), rise (1-cycle pulse out).
module rt_edge_det (
    input  logic axi_aclk,
    input  logic axi_aresetn,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/regfile_timer.sv
// Purpose: programmable interval timer / PWM fed by ctrl/period/compare register words.
// Latency: CLR/ACK act 1 cycle after their edge is seen; count/status update on the edge after a tick; irq/pwm lag one more cycle.
// Backpressure: none; register levels are sampled every cycle, no handshakes.
// Ports: ctrl_i (EN/ONESHOT/CLR/ACK/IRQ_EN), period_i (terminal count), compare_i (PWM threshold),
//        count_o, wraps_o, status_o ({overrun, irq_pending, state}), irq_o, pwm_o.
module regfile_timer
    import regfile_timer_pkg::*;
#(
    parameter int CW       = 32,
    parameter int PRESCALE = 1
) (
    input  logic          axi_aclk,
    input  logic          axi_aresetn,
    input  logic [31:0]   ctrl_i,
    input  logic [CW-1:0] period_i,
    input  logic [CW-1:0] compare_i,
    output logic [CW-1:0] count_o,
    output logic [31:0]   wraps_o,
    output logic [31:0]   status_o,
    output logic          irq_o,
    output logic          pwm_o
);

    localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

    state_t          state_q, state_n;
    logic [CW-1:0]   count_q, count_n;
    logic [31:0]     wraps_q, wraps_n;
    logic [PW-1:0]   presc_q, presc_n;
    logic            pend_q, pend_n;
    logic            ovr_q, ovr_n;
    logic            irq_q, pwm_q;
    logic            tick;
    logic            clr_pls, ack_pls;

    logic en, oneshot, irq_en;
    assign en      = ctrl_i[CTRL_EN];
    assign oneshot = ctrl_i[CTRL_ONESHOT];
    assign irq_en  = ctrl_i[CTRL_IRQ_EN];

    // reserved control bits are ignored
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^ctrl_i[31:5];

    rt_edge_det u_clr_edge (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .d           (ctrl_i[CTRL_CLR]),
        .rise        (clr_pls)
    );

    rt_edge_det u_ack_edge (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .d           (ctrl_i[CTRL_ACK]),
        .rise        (ack_pls)
    );

    always_comb begin
        state_n = state_q;
        count_n = count_q;
        wraps_n = wraps_q;
        presc_n = '0;
        pend_n  = pend_q;
        ovr_n   = ovr_q;
        tick    = 1'b0;

        // ACK is applied first so a terminal tick in the same cycle re-raises pending
        if (ack_pls) begin
            pend_n = 1'b0;
            ovr_n  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // count is held so EN low/high acts as pause/resume
                if (en && (period_i != '0)) state_n = ST_RUN;
            end
            ST_RUN: begin
                tick    = (presc_q == PS_LAST);
                presc_n = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    // >= so that lowering period below the live count still wraps
                    if (count_q >= period_i) begin
                        count_n = '0;
                        wraps_n = wraps_q + 32'd1;
                        ovr_n   = ovr_n | pend_n;
                        pend_n  = 1'b1;
                        if (oneshot) state_n = ST_DONE;
                    end else begin
                        count_n = count_q + CW'(1);
                    end
                end
                // the tick above still completes on the cycle EN drops
                if (!en || (period_i == '0)) begin
                    state_n = ST_IDLE;
                    presc_n = '0;
                end
            end
            ST_DONE: begin
                if (!en) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // CLR overrides everything, including a same-cycle wrap
        if (clr_pls) begin
            state_n = ST_IDLE;
            count_n = '0;
            wraps_n = '0;
            presc_n = '0;
            pend_n  = 1'b0;
            ovr_n   = 1'b0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            wraps_q <= '0;
            presc_q <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            irq_q   <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            wraps_q <= wraps_n;
            presc_q <= presc_n;
            pend_q  <= pend_n;
            ovr_q   <= ovr_n;
            irq_q   <= pend_q & irq_en;
            pwm_q   <= (state_q == ST_RUN) && (count_q < compare_i);
        end
    end

    always_comb begin
        status_o = '0;
        status_o[STAT_STATE_MSB:STAT_STATE_LSB] = state_q;
        status_o[STAT_IRQ_PEND] = pend_q;
        status_o[STAT_OVERRUN]  = ovr_q;
    end

    assign count_o = count_q;
    assign wraps_o = wraps_q;
    assign irq_o   = irq_q;
    assign pwm_o   = pwm_q;

endmodule
